// File: rtl/hazard_stall_ctrl_if.sv
// Pipeline-side bundle for the hazard/stall sequencer.
// master = pipeline datapath, slave = hazard_stall_ctrl.
interface hazard_stall_ctrl_if #(
    parameter int CNT_W = 16
);
    logic [31:0]      Instruction_IN;
    logic             IDEX_MemRead;
    logic             IDEX_RegWrite;
    logic [4:0]       IDEX_RegD;
    logic             EXMEM_MemRead;
    logic [4:0]       EXMEM_RegD;
    logic             Mem_Ready;
    logic             Stall_PC;
    logic             Stall_IFID;
    logic             Bubble_IDEX;
    logic             Freeze_All;
    logic [CNT_W-1:0] Stall_Cycles;
    logic             Timeout_Err;

    modport master (
        output Instruction_IN,
        output IDEX_MemRead,
        output IDEX_RegWrite,
        output IDEX_RegD,
        output EXMEM_MemRead,
        output EXMEM_RegD,
        output Mem_Ready,
        input  Stall_PC,
        input  Stall_IFID,
        input  Bubble_IDEX,
        input  Freeze_All,
        input  Stall_Cycles,
        input  Timeout_Err
    );

    modport slave (
        input  Instruction_IN,
        input  IDEX_MemRead,
        input  IDEX_RegWrite,
        input  IDEX_RegD,
        input  EXMEM_MemRead,
        input  EXMEM_RegD,
        input  Mem_Ready,
        output Stall_PC,
        output Stall_IFID,
        output Bubble_IDEX,
        output Freeze_All,
        output Stall_Cycles,
        output Timeout_Err
    );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// Hazard sequencer: load-use / branch-operand stalls and memory-wait freeze,
// with a saturating stall counter and a sticky memory-wait timeout flag.
module hazard_stall_ctrl #(
    parameter int CNT_W          = 16,
    parameter int FREEZE_TIMEOUT = 255
) (
    input logic               CLOCK,
    input logic               RESET,
    hazard_stall_ctrl_if.slave hs
);
    typedef enum logic [1:0] {
        RUN    = 2'd0,
        STALL  = 2'd1,
        FREEZE = 2'd2
    } state_t;

    localparam logic [15:0] TMO = FREEZE_TIMEOUT[15:0];

    state_t           state_q, state_d;
    state_t           sv_state_q, sv_state_d;
    state_t           eff_state;
    logic [1:0]       cnt_q, cnt_d;
    logic [1:0]       sv_cnt_q, sv_cnt_d;
    logic [1:0]       eff_cnt;
    logic [15:0]      frz_q, frz_d;
    logic             tout_q, tout_d;
    logic [CNT_W-1:0] cyc_q, cyc_d;

    logic [5:0] op;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       rt_src;
    logic       is_br;
    logic       idex_hit;
    logic       exmem_hit;
    logic       lu;
    logic       br_ex;
    logic       br_mem;
    logic [1:0] n_len;
    logic       stall;
    logic       bubble;
    logic       freeze;
    logic       stall_pc;

    assign op = hs.Instruction_IN[31:26];
    assign rs = hs.Instruction_IN[25:21];
    assign rt = hs.Instruction_IN[20:16];

    always_comb begin
        rt_src = 1'b0;
        case (op)
            6'h00, 6'h04, 6'h05, 6'h2B: rt_src = 1'b1;
            default:                    rt_src = 1'b0;
        endcase
    end

    assign is_br = (op == 6'h04) || (op == 6'h05);

    // $0 is never a real producer, so it cannot create a dependence
    assign idex_hit  = (hs.IDEX_RegD != 5'd0) &&
                       ((hs.IDEX_RegD == rs) ||
                        (rt_src && (hs.IDEX_RegD == rt)));
    assign exmem_hit = (hs.EXMEM_RegD != 5'd0) &&
                       ((hs.EXMEM_RegD == rs) ||
                        (rt_src && (hs.EXMEM_RegD == rt)));

    assign lu     = hs.IDEX_MemRead && idex_hit;
    assign br_ex  = is_br && hs.IDEX_RegWrite && idex_hit;
    assign br_mem = is_br && hs.EXMEM_MemRead && exmem_hit;

    always_comb begin
        n_len = 2'd0;
        if (lu || br_mem || br_ex) begin
            n_len = 2'd1;
        end
        if (br_ex && hs.IDEX_MemRead) begin
            n_len = 2'd2;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        sv_state_d = sv_state_q;
        sv_cnt_d   = sv_cnt_q;
        eff_state  = state_q;
        eff_cnt    = cnt_q;
        stall      = 1'b0;
        bubble     = 1'b0;
        freeze     = 1'b0;

        // leaving FREEZE behaves as the restored state in the same cycle
        if (state_q == FREEZE) begin
            eff_state = sv_state_q;
            eff_cnt   = sv_cnt_q;
        end

        if (!hs.Mem_Ready) begin
            freeze = 1'b1;
            stall  = 1'b1;
            if (state_q != FREEZE) begin
                sv_state_d = state_q;
                sv_cnt_d   = cnt_q;
                state_d    = FREEZE;
            end
        end else begin
            state_d = eff_state;
            cnt_d   = eff_cnt;
            case (eff_state)
                RUN: begin
                    if (n_len != 2'd0) begin
                        stall  = 1'b1;
                        bubble = 1'b1;
                        if (n_len == 2'd2) begin
                            cnt_d   = 2'd1;
                            state_d = STALL;
                        end
                    end
                end
                STALL: begin
                    stall  = 1'b1;
                    bubble = 1'b1;
                    if (eff_cnt <= 2'd1) begin
                        cnt_d   = 2'd0;
                        state_d = RUN;
                    end else begin
                        cnt_d = eff_cnt - 2'd1;
                    end
                end
                default: begin
                    cnt_d   = 2'd0;
                    state_d = RUN;
                end
            endcase
        end
    end

    always_comb begin
        frz_d  = frz_q;
        tout_d = tout_q;
        if (!hs.Mem_Ready) begin
            if (frz_q < TMO) begin
                frz_d = frz_q + 16'd1;
                if ((frz_q + 16'd1) == TMO) begin
                    tout_d = 1'b1;
                end
            end
        end else begin
            frz_d = 16'd0;
        end
    end

    assign stall_pc = stall && RESET;

    always_comb begin
        cyc_d = cyc_q;
        if (stall_pc && (cyc_q != {CNT_W{1'b1}})) begin
            cyc_d = cyc_q + 1'b1;
        end
    end

    always_ff @(posedge CLOCK) begin
        if (!RESET) begin
            state_q    <= RUN;
            cnt_q      <= 2'd0;
            sv_state_q <= RUN;
            sv_cnt_q   <= 2'd0;
            frz_q      <= 16'd0;
            tout_q     <= 1'b0;
            cyc_q      <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            sv_state_q <= sv_state_d;
            sv_cnt_q   <= sv_cnt_d;
            frz_q      <= frz_d;
            tout_q     <= tout_d;
            cyc_q      <= cyc_d;
        end
    end

    assign hs.Stall_PC     = stall_pc;
    assign hs.Stall_IFID   = stall_pc;
    assign hs.Bubble_IDEX  = bubble && RESET;
    assign hs.Freeze_All   = freeze && RESET;
    assign hs.Timeout_Err  = tout_q && RESET;
    assign hs.Stall_Cycles = cyc_q;
endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed bench for hazard_stall_ctrl: per-cycle expectations queued by the
// driver and checked by an independent monitor on the falling edge.
module tb_hazard_stall_ctrl;
    localparam logic [31:0] NOP  = 32'h0000_0000;
    localparam logic [31:0] ADD  = 32'h0044_1820;
    localparam logic [31:0] ADD0 = 32'h0004_1820;
    localparam logic [31:0] ADDI = 32'h2022_0005;
    localparam logic [31:0] BEQ  = 32'h10A0_0000;
    localparam logic [31:0] BNE  = 32'h14C7_0000;
    localparam logic [31:0] SW   = 32'hAC22_0000;

    typedef struct {
        int         id;
        logic       spc;
        logic       bub;
        logic       frz;
        logic [3:0] cyc;
        logic       to;
    } exp_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;
    exp_t q[$];

    hazard_stall_ctrl_if #(.CNT_W(4)) hs ();

    hazard_stall_ctrl #(
        .CNT_W         (4),
        .FREEZE_TIMEOUT(4)
    ) dut (
        .CLOCK(clk),
        .RESET(rst_n),
        .hs   (hs)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void chk(input string nm, input int id,
                                input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s vec=%0d got=%0d exp=%0d", nm, id, act, exp);
        end
    endfunction

    task automatic step(input int id, input logic r, input logic [31:0] ins,
                        input logic imr, input logic irw, input logic [4:0] ird,
                        input logic emr, input logic [4:0] erd, input logic mrdy,
                        input logic e_spc, input logic e_bub, input logic e_frz,
                        input logic [3:0] e_cyc, input logic e_to);
        exp_t e;
        @(posedge clk);
        #1;
        rst_n             = r;
        hs.Instruction_IN = ins;
        hs.IDEX_MemRead   = imr;
        hs.IDEX_RegWrite  = irw;
        hs.IDEX_RegD      = ird;
        hs.EXMEM_MemRead  = emr;
        hs.EXMEM_RegD     = erd;
        hs.Mem_Ready      = mrdy;
        e.id  = id;
        e.spc = e_spc;
        e.bub = e_bub;
        e.frz = e_frz;
        e.cyc = e_cyc;
        e.to  = e_to;
        q.push_back(e);
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() != 0) begin
                e = q.pop_front();
                chk("stall_pc", e.id, int'(hs.Stall_PC), int'(e.spc));
                chk("stall_ifid", e.id, int'(hs.Stall_IFID), int'(e.spc));
                chk("bubble", e.id, int'(hs.Bubble_IDEX), int'(e.bub));
                chk("freeze", e.id, int'(hs.Freeze_All), int'(e.frz));
                chk("stall_cycles", e.id, int'(hs.Stall_Cycles), int'(e.cyc));
                chk("timeout", e.id, int'(hs.Timeout_Err), int'(e.to));
            end
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        checks            = 0;
        failures          = 0;
        rst_n             = 1'b0;
        hs.Instruction_IN = NOP;
        hs.IDEX_MemRead   = 1'b0;
        hs.IDEX_RegWrite  = 1'b0;
        hs.IDEX_RegD      = 5'd0;
        hs.EXMEM_MemRead  = 1'b0;
        hs.EXMEM_RegD     = 5'd0;
        hs.Mem_Ready      = 1'b1;
        repeat (2) @(posedge clk);

        step(0, 0, NOP, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        step(1, 1, ADD, 1, 1, 2, 0, 0, 1, 1, 1, 0, 0, 0);
        step(2, 1, NOP, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0);
        step(3, 1, BEQ, 1, 1, 5, 0, 0, 1, 1, 1, 0, 1, 0);
        step(4, 1, BEQ, 1, 1, 5, 0, 0, 1, 1, 1, 0, 2, 0);
        step(5, 1, NOP, 0, 0, 0, 0, 0, 1, 0, 0, 0, 3, 0);
        step(6, 1, ADD0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 3, 0);
        step(7, 1, ADDI, 1, 0, 2, 0, 0, 1, 0, 0, 0, 3, 0);
        step(8, 1, BEQ, 0, 0, 0, 1, 5, 1, 1, 1, 0, 3, 0);
        step(9, 1, NOP, 0, 0, 0, 0, 0, 1, 0, 0, 0, 4, 0);
        step(10, 1, BNE, 0, 1, 7, 0, 0, 1, 1, 1, 0, 4, 0);
        step(11, 1, NOP, 0, 0, 0, 0, 0, 1, 0, 0, 0, 5, 0);
        step(12, 1, SW, 1, 0, 2, 0, 0, 1, 1, 1, 0, 5, 0);
        step(13, 1, NOP, 0, 0, 0, 0, 0, 1, 0, 0, 0, 6, 0);
        step(14, 1, BEQ, 1, 1, 5, 0, 0, 1, 1, 1, 0, 6, 0);
        step(15, 1, NOP, 0, 0, 0, 0, 0, 0, 1, 0, 1, 7, 0);
        step(16, 1, NOP, 0, 0, 0, 0, 0, 0, 1, 0, 1, 8, 0);
        step(17, 1, NOP, 0, 0, 0, 0, 0, 0, 1, 0, 1, 9, 0);
        step(18, 1, NOP, 0, 0, 0, 0, 0, 1, 1, 1, 0, 10, 0);
        step(19, 1, NOP, 0, 0, 0, 0, 0, 1, 0, 0, 0, 11, 0);
        step(20, 1, ADD, 1, 0, 2, 0, 0, 0, 1, 0, 1, 11, 0);
        step(21, 1, ADD, 1, 0, 2, 0, 0, 1, 1, 1, 0, 12, 0);
        step(22, 1, NOP, 0, 0, 0, 0, 0, 1, 0, 0, 0, 13, 0);
        step(23, 1, ADD, 1, 0, 2, 0, 0, 1, 1, 1, 0, 13, 0);
        step(24, 1, ADD, 1, 0, 2, 0, 0, 1, 1, 1, 0, 14, 0);
        step(25, 1, ADD, 1, 0, 2, 0, 0, 1, 1, 1, 0, 15, 0);
        step(26, 1, ADD, 1, 0, 2, 0, 0, 1, 1, 1, 0, 15, 0);
        step(27, 1, NOP, 0, 0, 0, 0, 0, 1, 0, 0, 0, 15, 0);
        step(28, 1, NOP, 0, 0, 0, 0, 0, 0, 1, 0, 1, 15, 0);
        step(29, 1, NOP, 0, 0, 0, 0, 0, 0, 1, 0, 1, 15, 0);
        step(30, 1, NOP, 0, 0, 0, 0, 0, 0, 1, 0, 1, 15, 0);
        step(31, 1, NOP, 0, 0, 0, 0, 0, 0, 1, 0, 1, 15, 0);
        step(32, 1, NOP, 0, 0, 0, 0, 0, 1, 0, 0, 0, 15, 1);
        step(33, 1, NOP, 0, 0, 0, 0, 0, 1, 0, 0, 0, 15, 1);
        step(34, 1, BEQ, 1, 1, 5, 0, 0, 1, 1, 1, 0, 15, 1);
        step(35, 0, NOP, 0, 0, 0, 0, 0, 1, 0, 0, 0, 15, 0);
        step(36, 1, NOP, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        step(37, 1, ADD, 1, 0, 2, 0, 0, 1, 1, 1, 0, 0, 0);
        step(38, 1, NOP, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0);

        for (int i = 0; i < 20 && q.size() != 0; i++) begin
            @(negedge clk);
        end
        #1;
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL drain got=%0d exp=0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
